// File: rtl/mdu.sv
// Multiply/divide unit for the EX stage: private HI/LO pair, fixed-latency busy
// window, and the stall request used by the hazard unit for HI/LO consumers.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_uses_md,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        delay_mdu
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_res_hi;
    logic [31:0]      r_res_lo;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;

    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_sdiv_q;
    logic signed [31:0] w_sdiv_r;
    logic [31:0]        w_udiv_q;
    logic [31:0]        w_udiv_r;
    logic               w_b_zero;
    logic               w_div_ovf;
    logic               w_is_md;
    logic               w_is_div;
    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;

    assign w_smul    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul    = {32'h0, a} * {32'h0, b};
    assign w_b_zero  = (b == 32'h0);
    assign w_div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_sdiv_q  = $signed(a) / $signed(b);
    assign w_sdiv_r  = $signed(a) % $signed(b);
    assign w_udiv_q  = a / b;
    assign w_udiv_r  = a % b;
    assign w_is_md   = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                       (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign w_is_div  = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);

    // Divide by zero re-commits the current HI/LO, which cannot change while busy.
    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (mdu_op)
            OP_MULT:  {w_res_hi, w_res_lo} = w_smul;
            OP_MULTU: {w_res_hi, w_res_lo} = w_umul;
            OP_DIV: begin
                if (w_div_ovf) begin
                    w_res_hi = 32'h0;
                    w_res_lo = 32'h8000_0000;
                end else if (!w_b_zero) begin
                    w_res_hi = w_sdiv_r;
                    w_res_lo = w_sdiv_q;
                end
            end
            OP_DIVU: begin
                if (!w_b_zero) begin
                    w_res_hi = w_udiv_r;
                    w_res_lo = w_udiv_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi     <= 32'h0;
            r_lo     <= 32'h0;
            r_res_hi <= 32'h0;
            r_res_lo <= 32'h0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
        end else if (r_busy) begin
            if (r_cnt == CNT_ONE) begin
                r_hi   <= r_res_hi;
                r_lo   <= r_res_lo;
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else if (start) begin
            if (w_is_md) begin
                r_res_hi <= w_res_hi;
                r_res_lo <= w_res_lo;
                r_cnt    <= w_is_div ? DIV_CNT : MULT_CNT;
                r_busy   <= 1'b1;
            end else if (mdu_op == OP_MTHI) begin
                r_hi <= a;
            end else if (mdu_op == OP_MTLO) begin
                r_lo <= a;
            end
        end
    end

    assign busy      = r_busy;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign delay_mdu = d_uses_md & (r_busy | (start & w_is_md));

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit in the EX stage of the five-stage pipeline. Executes mult, multu, div, divu, mthi and mtlo against a private HI/LO register pair, models the multi-cycle latency with a busy counter, and produces `delay_mdu`, the MDU stall request consumed by the hazard/forwarding unit to hold any HI/LO-touching instruction in the decode stage while the unit is occupied.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu (≥1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥1)

- `clk`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  EX-stage instruction is an MDU operation; sampled with `mdu_op`
- `mdu_op`  in  3  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0/7 no-op
- `a`  in  32  forwarded rs operand from EX
- `b`  in  32  forwarded rt operand from EX
- `d_uses_md`  in  1  decode-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- `busy`  out  1  operation in progress
- `hi`  out  32  HI register
- `lo`  out  32  LO register
- `delay_mdu`  out  1  stall request to hazard unit

## Operation
- State: `hi`, `lo`, `busy`, down-counter `cnt` (width for max(MULT_CYCLES, DIV_CYCLES)), pending `res_hi`/`res_lo`.
- Idle (`busy`=0), edge with `start`=1:
  - op 1: {res_hi,res_lo} = signed(a)*signed(b), 64-bit; cnt←MULT_CYCLES; busy←1.
  - op 2: unsigned 64-bit product; cnt←MULT_CYCLES; busy←1.
  - op 3: signed divide, truncation toward zero; res_lo=quotient, res_hi=remainder (sign of dividend); cnt←DIV_CYCLES; busy←1.
  - op 4: unsigned divide; same register mapping; cnt←DIV_CYCLES; busy←1.
  - op 5: hi←a at this edge; busy stays 0. op 6: lo←a likewise.
  - op 0/7: no effect.
- Busy: each edge cnt←cnt−1; at the edge where cnt==1: hi←res_hi, lo←res_lo, busy←0, cnt←0.
- `start` while busy: ignored entirely (hazard unit prevents it; block still must not corrupt state).
- Divide by zero (b==0, op 3/4): full DIV_CYCLES latency; hi/lo unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- `delay_mdu` = `d_uses_md` & (`busy` | (`start` & `mdu_op` ∈ {1,2,3,4})); combinational.
- mfhi/mflo read `hi`/`lo` directly; no internal bypass of in-flight results.

## Timing
- Reset (async, immediate on `reset_n`=0): hi=0, lo=0, busy=0, cnt=0, pending results=0; `delay_mdu` reduces to `d_uses_md`&`start`-term only. Reset mid-operation aborts it; hi/lo not updated.
- mult issued at edge T0: busy=1 in cycles T0..T0+MULT_CYCLES−1 (exactly MULT_CYCLES cycles), new hi/lo visible from cycle after busy falls. Div likewise with DIV_CYCLES.
- Back-to-back: new `start` accepted at the edge where busy falls? No — accepted only when busy=0 at the sampling edge; earliest re-issue is the edge after completion.
- mthi/mtlo: zero latency; value visible the cycle after the edge.
- `delay_mdu` asserts in the same cycle `start` is presented for ops 1–4, so a following MD instruction in D stalls immediately.

## Test plan
- Reset: assert `reset_n`=0 mid-div (cnt=4) -> hi=lo=0, busy=0 immediately; after release a 0x5×0x3 mult gives lo=0xF, hi=0.
- mult a=0xFFFFFFFF, b=0x2 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; multu same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (−7), b=2 -> busy 10 cycles, lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1); divu a=7,b=2 -> lo=3, hi=1.
- Boundaries: div by 0 with hi=0x11,lo=0x22 preloaded via mthi/mtlo -> after 10 cycles hi=0x11, lo=0x22; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Stall: `d_uses_md`=1 throughout mult -> `delay_mdu`=1 in issue cycle and all 5 busy cycles, 0 after; `d_uses_md`=0 -> `delay_mdu`=0 always.
- `start` with op 3 during an active mult -> ignored; mult result committed unchanged, busy falls on schedule.
